// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg: registered NUM_CH:1 multiplexer with valid/ready handshaking.
// The channel is chosen by an explicit select (mode_i = 0) or round-robin
// (mode_i = 1), and the chosen word is held until downstream accepts it.
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset
//   data_i    NUM_CH packed words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_i   per-channel word valid
//   ready_o   per-channel accept (combinational, one-hot or zero)
//   mode_i    0 = explicit select, 1 = round-robin
//   select_i  channel index used in explicit mode
//   data_o    registered output word
//   chan_o    registered index of the channel that supplied data_o
//   valid_o   output register holds an unaccepted word
//   ready_i   downstream accept
module mux_n_to_1_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]            valid_i,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic                         mode_i,
  input  logic [SEL_WIDTH-1:0]         select_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [SEL_WIDTH-1:0]         chan_o,
  output logic                         valid_o,
  input  logic                         ready_i
);

  // Index space covered by a SEL_WIDTH-bit select; may exceed NUM_CH.
  localparam int unsigned PAD = 32'(1) << SEL_WIDTH;

  logic [PAD-1:0]        valid_pad;
  logic [DATA_WIDTH-1:0] words [PAD];
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic                  rr_found;
  logic [SEL_WIDTH-1:0]  rr_idx;
  logic                  sel_in_range;
  logic                  load_en;
  logic                  grant;
  logic [SEL_WIDTH-1:0]  cand;

  // Pad valid and data out to the full select range; missing channels read as idle zero.
  assign valid_pad = PAD'(valid_i);

  for (genvar k = 0; k < PAD; k++) begin : g_words
    if (k < NUM_CH) begin : g_real
      assign words[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign words[k] = '0;
    end
  end

  // Output register may take a new word when empty or being drained this cycle.
  assign load_en      = !valid_o || ready_i;
  assign sel_in_range = 32'(select_i) < NUM_CH;

  // Round-robin search: first valid channel after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    int unsigned pos;
    rr_found = 1'b0;
    rr_idx   = '0;
    pos      = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NUM_CH) begin
        pos = pos - NUM_CH;
      end
      if (!rr_found && valid_pad[SEL_WIDTH'(pos)]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_WIDTH'(pos);
      end
    end
  end

  // Grant decision; reset and a full, stalled output register suppress it.
  always_comb begin
    grant = 1'b0;
    cand  = '0;
    if (mode_i) begin
      grant = rr_found;
      cand  = rr_idx;
    end else begin
      grant = sel_in_range && valid_pad[select_i];
      cand  = select_i;
    end
    grant = grant && load_en && !rst_i;
  end

  // One-hot accept towards the granted producer.
  always_comb begin
    ready_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ready_o[k] = grant && (cand == SEL_WIDTH'(k));
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      chan_o  <= '0;
      valid_o <= 1'b0;
      rr_ptr  <= SEL_WIDTH'(NUM_CH - 1);
    end else if (grant) begin
      data_o  <= words[cand];
      chan_o  <= cand;
      valid_o <= 1'b1;
      if (mode_i) begin
        rr_ptr <= cand;
      end
    end else if (load_en) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/mux_n_to_1_reg.md
# mux_n_to_1_reg

Registered N-channel, parametrised-width multiplexer with valid/ready handshaking, for the floating-point square-root datapath. Selects one of NUM_CH input channels by explicit select or by round-robin arbitration, and holds the chosen word in an output register until downstream accepts it. Used where several datapath producers (operand latch, iteration result, special-case constant) share one consumer. Replaces fixed 2:1 combinational muxes wherever a stage boundary is needed.

## Interface
- DATA_WIDTH, 32, bits per channel word
- NUM_CH, 4, number of input channels (2..16)
- SEL_WIDTH, 2, width of select_i and chan_o; must satisfy 2^SEL_WIDTH >= NUM_CH

- clk_i  input  1  single clock; all state changes on rising edge
- rst_i  input  1  synchronous, active-high reset
- data_i  input  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- valid_i  input  NUM_CH  per-channel word-valid
- ready_o  output  NUM_CH  per-channel accept; combinational, one-hot or zero
- mode_i  input  1  0 = explicit select, 1 = round-robin
- select_i  input  SEL_WIDTH  channel index, used only in mode 0
- data_o  output  DATA_WIDTH  registered output word
- chan_o  output  SEL_WIDTH  registered index of the channel that supplied data_o
- valid_o  output  1  output register holds an unaccepted word
- ready_i  input  1  downstream accept

## Operation
- load_en = !valid_o || ready_i. Grants are only possible when load_en = 1.
- Mode 0: the candidate is select_i.
  - If select_i >= NUM_CH, there is no grant.
  - Otherwise the grant is issued when valid_i[select_i] = 1.
- Mode 1: the candidate is the first channel with valid_i = 1, searching rr_ptr+1, rr_ptr+2, … modulo NUM_CH.
  - rr_ptr is an internal SEL_WIDTH register.
  - On a grant in mode 1, rr_ptr <= granted index.
  - rr_ptr is unchanged on no grant and in mode 0.
- On a grant to channel g:
  - ready_o[g] = 1 and all other ready_o bits are 0.
  - Next edge: data_o <= channel g word, chan_o <= g, valid_o <= 1.
- Without a grant:
  - If load_en = 1, then valid_o <= 0, and data_o and chan_o hold their last value.
  - If load_en = 0, all outputs hold.
- Transfer into the block happens when valid_i[k] && ready_o[k]. Transfer out happens when valid_o && ready_i.
- ready_o never depends on valid_i of other channels in mode 0. In mode 1 it depends on all valid_i bits and rr_ptr.
- A change on mode_i takes effect combinationally in the same cycle. rr_ptr is never cleared by a mode change.

## Timing
- Reset (rst_i = 1 at an edge): data_o = 0, chan_o = 0, valid_o = 0, rr_ptr = NUM_CH-1, so channel 0 has first priority.
  - While rst_i = 1, ready_o = 0 and no grant is issued.
  - Reset mid-hold discards the held word.
- Latency: 1 cycle from accepted input to valid_o.
- Throughput: 1 word/cycle when ready_i stays 1.
- Backpressure: while valid_o && !ready_i, data_o and chan_o are stable and ready_o = 0.
- Simultaneous accept and load (valid_o && ready_i && grant): the new word replaces the old one in the same edge, with no bubble.
- Round-robin wrap: with rr_ptr = NUM_CH-1 the search starts at channel 0.
- A single valid channel is granted every cycle, regardless of rr_ptr.
- No combinational path from ready_i to data_o. A path from ready_i to ready_o is permitted.

## Test plan
- Reset then mode 0: select_i=2, valid_i=4'b0100, ch2=32'h3F800000, ready_i=1 -> ready_o=4'b0100 the same cycle; next cycle data_o=32'h3F800000, chan_o=2, valid_o=1.
- Backpressure: hold ready_i=0 for 3 cycles with new ch2 data -> data_o stays 32'h3F800000 and ready_o=0 throughout. Raise ready_i -> new word appears on the next cycle with no bubble.
- Round-robin with NUM_CH=4: valid_i=4'b1111 and ready_i=1 from reset -> chan_o sequence 0,1,2,3,0. Then valid_i=4'b1010 -> sequence alternates 1,3.
- Out-of-range select: NUM_CH=3, SEL_WIDTH=2, select_i=3, all valid -> ready_o=0 and valid_o falls to 0 after the pending word is accepted.
- Reset mid-hold: valid_o=1, ready_i=0, assert rst_i for one cycle -> next cycle valid_o=0, data_o=0, chan_o=0. The first round-robin grant afterwards goes to channel 0.
- Mode switch: in mode 1 after granting channel 2, switch to mode 0 with select_i=0, then back to mode 1 with all valid -> grants go ch0, then ch3 (rr_ptr is retained).
